// File: rtl/regfile_writer_if.sv
// Bundle between writeback producers, decode and the regfile write-side block.
// The master side drives requests and source selects; the slave side is regfile_writer.
interface regfile_writer_if;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic        drain_en;
    logic        rf_load;
    logic [2:0]  rf_dest;
    logic [15:0] rf_in;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        sb_err;

    modport master (
        output issue_valid, issue_dest, wb_valid, wb_dest, wb_data, drain_en, src_a, src_b,
        input  issue_ready, wb_ready, rf_load, rf_dest, rf_in, hazard_a, hazard_b, sb_err
    );

    modport slave (
        input  issue_valid, issue_dest, wb_valid, wb_dest, wb_data, drain_en, src_a, src_b,
        output issue_ready, wb_ready, rf_load, rf_dest, rf_in, hazard_a, hazard_b, sb_err
    );
endinterface

// File: rtl/regfile_writer.sv
// In-order writeback FIFO driving the 8 x 16 regfile write port, plus a per-register
// outstanding-write scoreboard that reports read-after-write hazards to decode.
module regfile_writer #(
    parameter int DEPTH  = 4,
    parameter int PEND_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    regfile_writer_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

    logic [2:0]        dest_mem_q [DEPTH];
    logic [15:0]       data_mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PEND_W-1:0] pending_q [8];
    logic [PEND_W-1:0] pending_d [8];
    logic              sb_err_q, sb_err_d;

    logic              push_s, pop_s, inc_s, not_empty_s;
    logic [2:0]        head_dest_s;
    logic [15:0]       head_data_s;
    logic              wb_ready_s, issue_ready_s, hazard_a_s, hazard_b_s;

    // The final outstanding write is forwarded by the regfile in its drain cycle, so it is no hazard.
    function automatic logic hazard_f(input logic [PEND_W-1:0] pend, input logic [2:0] src,
                                      input logic load, input logic [2:0] dest);
        return (pend != '0) && !(load && (dest == src) && (pend == PEND_ONE));
    endfunction

    // FIFO control, scoreboard next state and combinational outputs.
    always_comb begin
        not_empty_s   = (count_q != '0);
        wb_ready_s    = (count_q != COUNT_FULL);
        push_s        = bus.wb_valid && wb_ready_s;
        pop_s         = bus.drain_en && not_empty_s;
        head_dest_s   = not_empty_s ? dest_mem_q[head_q] : 3'd0;
        head_data_s   = not_empty_s ? data_mem_q[head_q] : 16'd0;
        issue_ready_s = (pending_q[bus.issue_dest] != PEND_MAX);
        inc_s         = bus.issue_valid && issue_ready_s;

        head_d   = pop_s  ? head_q + AW'(1) : head_q;
        tail_d   = push_s ? tail_q + AW'(1) : tail_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        sb_err_d = sb_err_q;
        for (int r = 0; r < 8; r++) begin
            pending_d[r] = pending_q[r];
            if (pop_s && (head_dest_s == 3'(r)) && (pending_q[r] == '0)) begin
                sb_err_d = 1'b1;
            end else begin
                sb_err_d = sb_err_d;
            end
            case ({inc_s && (bus.issue_dest == 3'(r)), pop_s && (head_dest_s == 3'(r))})
                2'b10:   pending_d[r] = pending_q[r] + PEND_ONE;
                2'b01:   pending_d[r] = (pending_q[r] == '0) ? pending_q[r] : pending_q[r] - PEND_ONE;
                default: pending_d[r] = pending_q[r];
            endcase
        end

        hazard_a_s = hazard_f(pending_q[bus.src_a], bus.src_a, pop_s, head_dest_s);
        hazard_b_s = hazard_f(pending_q[bus.src_b], bus.src_b, pop_s, head_dest_s);
    end

    // Control state: pointers, count, pending counters and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            sb_err_q <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                pending_q[r] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            sb_err_q <= sb_err_d;
            for (int r = 0; r < 8; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end
    end

    // Payload storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            dest_mem_q[tail_q] <= bus.wb_dest;
            data_mem_q[tail_q] <= bus.wb_data;
        end
    end

    assign bus.wb_ready    = wb_ready_s;
    assign bus.issue_ready = issue_ready_s;
    assign bus.rf_load     = pop_s;
    assign bus.rf_dest     = head_dest_s;
    assign bus.rf_in       = head_data_s;
    assign bus.hazard_a    = hazard_a_s;
    assign bus.hazard_b    = hazard_b_s;
    assign bus.sb_err      = sb_err_q;

endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Write-side companion to the 8 x 16-bit register file.
- Buffers completed results from the execute/memory stages in a small in-order FIFO and drives the regfile write port (load/dest/in) at one write per cycle.
- Keeps a per-register scoreboard of outstanding writes so decode can detect read-after-write hazards.
- Sits between writeback producers and the regfile; the hazard outputs feed the decode stall logic.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PEND_W, 2: width of each per-register pending counter; maximum outstanding writes per register is 2^PEND_W - 1.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- issue_valid  in  1  Decode is issuing an instruction that will write issue_dest.
- issue_dest  in  3  Destination register of the issuing instruction (lc3b_reg).
- issue_ready  out  1  Scoreboard can accept the issue.
- wb_valid  in  1  Producer presents a result.
- wb_dest  in  3  Result destination register.
- wb_data  in  16  Result value (lc3b_word).
- wb_ready  out  1  FIFO can accept the result.
- drain_en  in  1  Permits the FIFO to write the regfile this cycle.
- rf_load  out  1  Regfile write enable.
- rf_dest  out  3  Regfile write address.
- rf_in  out  16  Regfile write data.
- src_a, src_b  in  3 each  Decode source registers.
- hazard_a, hazard_b  out  1 each  Source register has a pending write not yet visible.
- sb_err  out  1  Sticky flag: a result arrived for a register with no pending issue.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - FIFO emptied; queued entries are discarded.
  - All pending counters cleared.
  - sb_err is 0.
  - rf_load, rf_dest and rf_in are all 0, because the outputs are taken from an empty FIFO.
- FIFO:
  - Storage holds {dest, data} pairs plus head and tail pointers and a count.
  - wb_ready = (count != DEPTH). It is combinational from the count and does not depend on same-cycle draining.
  - Enqueue on a clock edge when wb_valid && wb_ready.
  - Pointers wrap modulo DEPTH.
- Drain:
  - rf_load = drain_en && (count != 0).
  - rf_dest and rf_in always show the head entry, and are 0 when the FIFO is empty.
  - On an edge with rf_load high, the head is popped. The regfile captures the value on the same edge.
  - Latency: a result enqueued at edge N drives rf_load in the following cycle, provided the FIFO was empty and drain_en is high. It is written at edge N+1.
  - Writes leave in strict enqueue order.
  - Enqueue and pop on the same edge leave the count unchanged.
- Scoreboard:
  - pending[r] increments on issue_valid && issue_ready for issue_dest.
  - pending[r] decrements on rf_load for rf_dest.
  - Increment and decrement of the same register on the same edge leave it unchanged.
  - issue_ready = (pending[issue_dest] != 2^PEND_W - 1). An issue to a saturated register stalls.
  - A decrement when pending[rf_dest] == 0 leaves the counter at 0 and sets sb_err. The write itself still occurs.
  - sb_err clears only on reset.
- Hazards (combinational):
  - hazard_a = (pending[src_a] != 0) && !(rf_load && rf_dest == src_a && pending[src_a] == 1).
  - hazard_b uses the same rule with src_b.
  - Rationale: the regfile forwards a same-cycle write to its read ports, so the final outstanding write is already visible and does not stall.
  - A register with 2 or more writes pending stays hazarded while only one of them drains.
- All eight registers, including R0, are ordinary registers.

Test Plan:
- Reset then idle: rf_load=0, rf_dest=0, rf_in=0, wb_ready=1, issue_ready=1, hazard_a/b=0, sb_err=0.
- Issue R3, enqueue {R3, 16'h1234}, drain_en=1:
  - hazard_a=1 with src_a=3 before the drain cycle.
  - In the drain cycle: rf_load=1, rf_dest=3, rf_in=16'h1234, hazard_a=0.
  - After the edge, pending[3]=0.
- drain_en=0, issue and enqueue 4 results for R1..R4:
  - wb_ready drops to 0 after the 4th.
  - A 5th wb_valid is not accepted.
  - Raising drain_en writes R1, R2, R3, R4 in order on 4 consecutive cycles.
- Issue R5 three times (PEND_W=2):
  - issue_ready=0 for a 4th R5 issue.
  - After one drain of R5, issue_ready=1.
  - hazard on R5 stays 1 until the third write's drain cycle.
- Enqueue {R6, 16'hBEEF} with no prior issue: write still occurs, sb_err=1 and stays 1; pending[6]=0.
- Assert reset with 3 entries queued and pending counts nonzero: outputs go to 0 immediately, the queued writes never appear, and all hazards read 0.
